zero_qual16: RTL and testbench
==============================

ZERO_QUAL16 -- requirements
Module: zero_qual16

Interface
REQ-001 SHALL provide parameter: QUAL_CYCLES, 4, number of consecutive enabled zero samples required to qualify (legal 1..15).
REQ-002 SHALL provide port: CK  input  1  rising-edge clock, sole clock of the block.
REQ-003 SHALL provide port: CD  input  1  asynchronous active-high clear; one clock, reset asynchronous and active-high.
REQ-004 SHALL provide port: CE  input  1  clock enable for the sample register and the qualifier FSM.
REQ-005 SHALL provide port: A  input  16  data word to be zero-tested.
REQ-006 SHALL provide port: CLR_CNT  input  1  synchronous clear of ZCNT, independent of CE.
REQ-007 SHALL provide port: ZN_RAW  output  1  16-input NOR of the registered sample.
REQ-008 SHALL provide port: ZQ  output  1  qualified-zero level.
REQ-009 SHALL provide port: ZRISE  output  1  one-cycle pulse on ZQ 0->1.
REQ-010 SHALL provide port: ZFALL  output  1  one-cycle pulse on ZQ 1->0.
REQ-011 SHALL provide port: ZCNT  output  8  saturating count of qualified-zero events.

Function
REQ-012 SHALL capture A into 16-bit register a_q on each CK rise with CE=1; hold a_q when CE=0.
REQ-013 SHALL drive ZN_RAW = NOR of all 16 bits of a_q (combinational from a_q; one cycle latency from A).
REQ-014 SHALL implement FSM states IDLE, QUAL, ZERO, with 4-bit run counter run_cnt; FSM and run_cnt advance only on CK rises with CE=1.
REQ-015 IDLE: ZN_RAW=1 -> run_cnt=1, go ZERO if QUAL_CYCLES=1, else QUAL; ZN_RAW=0 -> stay, run_cnt=0.
REQ-016 QUAL: ZN_RAW=0 -> IDLE, run_cnt=0; ZN_RAW=1 and run_cnt+1=QUAL_CYCLES -> ZERO; otherwise run_cnt increments.
REQ-017 ZERO: ZN_RAW=0 -> IDLE, run_cnt=0; ZN_RAW=1 -> stay.
REQ-018 ZQ SHALL be registered and equal 1 exactly while state=ZERO.
REQ-019 Latency: with CE held 1, A=0 sampled at edge k and held -> ZQ=1 after edge k+QUAL_CYCLES; nonzero A sampled at edge m -> ZQ=0 after edge m+1.
REQ-020 ZRISE SHALL be 1 for exactly the one CK cycle in which ZQ first reads 1; ZFALL likewise for the cycle in which ZQ first reads 0; both SHALL deassert on the next CK rise regardless of CE.
REQ-021 ZRISE and ZFALL SHALL never be 1 in the same cycle.
REQ-022 ZCNT SHALL increment by 1 on each IDLE/QUAL->ZERO transition and saturate at 255 (no wrap).
REQ-023 CLR_CNT=1 SHALL set ZCNT to 0 on the next CK rise; when CLR_CNT coincides with an increment, clear wins (ZCNT=0).
REQ-024 A single nonzero sample during QUAL SHALL restart qualification from zero (no partial credit).

Reset
REQ-025 CD=1 SHALL asynchronously force: a_q=16'hFFFF (ZN_RAW=0), state=IDLE, run_cnt=0, ZQ=0, ZRISE=0, ZFALL=0, ZCNT=0.
REQ-026 CD asserted mid-qualification or in ZERO SHALL abort with no ZFALL pulse; after CD release, the first CK rise with CE=1 is treated as a fresh IDLE evaluation.
REQ-027 CD SHALL dominate CE and CLR_CNT.

Verification
REQ-028 QUAL_CYCLES=4, CE=1, A=0 from edge 1 -> ZN_RAW=1 after edge 1, ZQ=1 and ZRISE=1 after edge 5, ZCNT=1; ZRISE=0 after edge 6.
REQ-029 A=0 for 3 edges, 16'h0001 at edge 4, then 0 -> no ZRISE until 4 further zero samples; ZQ=1 after edge 9 (with A=0 at edges 5..8 captured, ZERO entered at edge 9).
REQ-030 In ZERO, A=16'h8000 sampled at edge m -> ZQ=0 and ZFALL=1 after edge m+1; ZFALL=0 after edge m+2.
REQ-031 CE=0 for 5 cycles during QUAL with A toggling -> ZQ, run_cnt, a_q unchanged; qualification resumes on CE=1.
REQ-032 Drive 260 qualify/release cycles -> ZCNT saturates at 255; CLR_CNT coincident with a ZRISE -> ZCNT=0.
REQ-033 Assert CD asynchronously between edges while ZQ=1 -> all outputs 0 immediately, ZN_RAW=0, no ZFALL pulse; QUAL_CYCLES=1 rerun -> ZQ=1 one edge after first zero sample.

Source files
------------

// File: rtl/zero_qual16.sv
// Qualified zero detector: registers a 16-bit sample, requires QUAL_CYCLES
// consecutive enabled zero samples before asserting ZQ, with edge pulses and an event counter.
module zero_qual16 #(
    parameter int QUAL_CYCLES = 4
) (
    input  logic        CK,
    input  logic        CD,
    input  logic        CE,
    input  logic [15:0] A,
    input  logic        CLR_CNT,
    output logic        ZN_RAW,
    output logic        ZQ,
    output logic        ZRISE,
    output logic        ZFALL,
    output logic [7:0]  ZCNT
);

    typedef enum logic [1:0] {IDLE, QUAL, ZERO} state_t;

    localparam logic [3:0] QC = 4'(QUAL_CYCLES);

    logic [15:0] a_q, a_d;
    state_t      state_q, state_d;
    logic [3:0]  run_cnt_q, run_cnt_d;
    logic        zq_q, zq_d;
    logic        zrise_q, zrise_d;
    logic        zfall_q, zfall_d;
    logic [7:0]  zcnt_q, zcnt_d;
    logic        zn_raw;
    logic        enter_zero;

    assign zn_raw = ~|a_q;

    always_comb begin
        a_d       = CE ? A : a_q;
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        if (CE) begin
            case (state_q)
                IDLE: begin
                    if (zn_raw) begin
                        run_cnt_d = 4'd1;
                        state_d   = (QC == 4'd1) ? ZERO : QUAL;
                    end else begin
                        run_cnt_d = 4'd0;
                    end
                end
                QUAL: begin
                    // any nonzero sample discards the partial run entirely
                    if (!zn_raw) begin
                        state_d   = IDLE;
                        run_cnt_d = 4'd0;
                    end else begin
                        run_cnt_d = run_cnt_q + 4'd1;
                        if (run_cnt_q + 4'd1 == QC) state_d = ZERO;
                    end
                end
                ZERO: begin
                    if (!zn_raw) begin
                        state_d   = IDLE;
                        run_cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    run_cnt_d = 4'd0;
                end
            endcase
        end

        // pulses derive from the level change, so they drop on the next edge even with CE low
        zq_d       = (state_d == ZERO);
        enter_zero = zq_d & ~zq_q;
        zrise_d    = enter_zero;
        zfall_d    = ~zq_d & zq_q;

        if (CLR_CNT)                             zcnt_d = 8'd0;
        else if (enter_zero && zcnt_q != 8'hFF)  zcnt_d = zcnt_q + 8'd1;
        else                                     zcnt_d = zcnt_q;
    end

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            a_q       <= 16'hFFFF;
            state_q   <= IDLE;
            run_cnt_q <= 4'd0;
            zq_q      <= 1'b0;
            zrise_q   <= 1'b0;
            zfall_q   <= 1'b0;
            zcnt_q    <= 8'd0;
        end else begin
            a_q       <= a_d;
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            zq_q      <= zq_d;
            zrise_q   <= zrise_d;
            zfall_q   <= zfall_d;
            zcnt_q    <= zcnt_d;
        end
    end

    assign ZN_RAW = zn_raw;
    assign ZQ     = zq_q;
    assign ZRISE  = zrise_q;
    assign ZFALL  = zfall_q;
    assign ZCNT   = zcnt_q;

endmodule

// File: tb/tb_zero_qual16.sv
// Directed bench for zero_qual16: QUAL_CYCLES=4 instance for most checks,
// a QUAL_CYCLES=1 instance for the single-sample qualification case.
module tb_zero_qual16;

    logic        CK = 1'b0;
    logic        CD, CE, CLR_CNT;
    logic [15:0] A;
    logic        zn0, zq0, zr0, zf0;
    logic [7:0]  zc0;
    logic        zn1, zq1, zr1, zf1;
    logic [7:0]  zc1;

    int n_cmp = 0;
    int n_mis = 0;

    zero_qual16 #(.QUAL_CYCLES(4)) dut (
        .CK(CK), .CD(CD), .CE(CE), .A(A), .CLR_CNT(CLR_CNT),
        .ZN_RAW(zn0), .ZQ(zq0), .ZRISE(zr0), .ZFALL(zf0), .ZCNT(zc0)
    );

    zero_qual16 #(.QUAL_CYCLES(1)) dut1 (
        .CK(CK), .CD(CD), .CE(CE), .A(A), .CLR_CNT(CLR_CNT),
        .ZN_RAW(zn1), .ZQ(zq1), .ZRISE(zr1), .ZFALL(zf1), .ZCNT(zc1)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // outputs are sampled 1 time unit after the rising edge; inputs change there too
    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic zq, input logic zr,
                           input logic zf, input logic [7:0] zc);
        chk({tag, ".ZQ"},    {15'd0, zq0}, {15'd0, zq});
        chk({tag, ".ZRISE"}, {15'd0, zr0}, {15'd0, zr});
        chk({tag, ".ZFALL"}, {15'd0, zf0}, {15'd0, zf});
        chk({tag, ".ZCNT"},  {8'd0, zc0},  {8'd0, zc});
    endtask

    initial begin
        CD = 1'b1; CE = 1'b1; CLR_CNT = 1'b0; A = 16'h0000;
        #12;
        chk("rst.ZN_RAW", {15'd0, zn0}, 16'd0);
        chk_out("rst", 1'b0, 1'b0, 1'b0, 8'd0);
        step();
        CD = 1'b0;

        // plain qualification: A=0 from edge 1
        step();
        chk("q.e1.ZN_RAW", {15'd0, zn0}, 16'd1);
        chk_out("q.e1", 1'b0, 1'b0, 1'b0, 8'd0);
        step(); step(); step();
        chk_out("q.e4", 1'b0, 1'b0, 1'b0, 8'd0);
        step();
        chk_out("q.e5", 1'b1, 1'b1, 1'b0, 8'd1);
        step();
        chk_out("q.e6", 1'b1, 1'b0, 1'b0, 8'd1);

        // release from ZERO
        A = 16'h8000;
        step();
        chk("rel.m.ZN_RAW", {15'd0, zn0}, 16'd0);
        chk_out("rel.m", 1'b1, 1'b0, 1'b0, 8'd1);
        step();
        chk_out("rel.m1", 1'b0, 1'b0, 1'b1, 8'd1);
        step();
        chk_out("rel.m2", 1'b0, 1'b0, 1'b0, 8'd1);

        // a single nonzero sample restarts qualification
        A = 16'h0000;
        step(); step(); step();
        A = 16'h0001;
        step();
        A = 16'h0000;
        for (int e = 5; e <= 8; e++) begin
            step();
            chk_out($sformatf("rs.e%0d", e), 1'b0, 1'b0, 1'b0, 8'd1);
        end
        step();
        chk_out("rs.e9", 1'b1, 1'b1, 1'b0, 8'd2);
        A = 16'hFFFF;
        step(); step();
        chk_out("rs.rel", 1'b0, 1'b0, 1'b1, 8'd2);
        step();

        // CE low mid-qualification freezes sample and run count
        A = 16'h0000;
        step(); step(); step();
        CE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            A = (i % 2 == 0) ? 16'h1234 : 16'h0000;
            step();
            chk($sformatf("ce.h%0d.ZN_RAW", i), {15'd0, zn0}, 16'd1);
            chk_out($sformatf("ce.h%0d", i), 1'b0, 1'b0, 1'b0, 8'd2);
        end
        CE = 1'b1; A = 16'h0000;
        step();
        chk_out("ce.r1", 1'b0, 1'b0, 1'b0, 8'd2);
        step();
        chk_out("ce.r2", 1'b1, 1'b1, 1'b0, 8'd3);
        A = 16'hFFFF;
        step(); step(); step();

        // 260 qualify/release cycles must saturate the counter
        for (int i = 0; i < 260; i++) begin
            A = 16'h0000;
            repeat (5) step();
            A = 16'hFFFF;
            repeat (2) step();
        end
        chk("sat.ZCNT", {8'd0, zc0}, 16'd255);

        // clear coincident with the rising pulse wins
        A = 16'h0000;
        repeat (4) step();
        CLR_CNT = 1'b1;
        step();
        chk_out("clr.rise", 1'b1, 1'b1, 1'b0, 8'd0);
        CLR_CNT = 1'b0;
        step();
        chk_out("clr.after", 1'b1, 1'b0, 1'b0, 8'd0);

        // clear works with CE low
        A = 16'hFFFF;
        step(); step(); step();
        A = 16'h0000;
        repeat (5) step();
        chk_out("clr2.q", 1'b1, 1'b1, 1'b0, 8'd1);
        CE = 1'b0; CLR_CNT = 1'b1;
        step();
        chk_out("clr2.ce0", 1'b1, 1'b0, 1'b0, 8'd0);
        CE = 1'b1; CLR_CNT = 1'b0;
        A = 16'hFFFF;
        step(); step(); step();
        A = 16'h0000;
        repeat (5) step();
        chk_out("cd.pre", 1'b1, 1'b1, 1'b0, 8'd1);
        step();

        // asynchronous clear while ZQ=1
        #3;
        CD = 1'b1;
        #1;
        chk("cd.ZN_RAW", {15'd0, zn0}, 16'd0);
        chk_out("cd.async", 1'b0, 1'b0, 1'b0, 8'd0);
        #2;
        CD = 1'b0;
        step();
        chk_out("cd.post", 1'b0, 1'b0, 1'b0, 8'd0);

        // single-sample qualification instance
        CD = 1'b1;
        #2;
        CD = 1'b0;
        A = 16'hFFFF;
        step();
        A = 16'h0000;
        step();
        chk("q1.k.ZN_RAW", {15'd0, zn1}, 16'd1);
        chk("q1.k.ZQ",     {15'd0, zq1}, 16'd0);
        step();
        chk("q1.k1.ZQ",    {15'd0, zq1}, 16'd1);
        chk("q1.k1.ZRISE", {15'd0, zr1}, 16'd1);
        chk("q1.k1.ZCNT",  {8'd0, zc1},  16'd1);
        A = 16'hFFFF;
        step(); step();
        chk("q1.rel.ZQ",    {15'd0, zq1}, 16'd0);
        chk("q1.rel.ZFALL", {15'd0, zf1}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
